// File: rtl/ref_rom_seq_if.sv
// Stream/ROM-side signal bundle for ref_rom_seq.
// slave = sequencer view, master = requester/ROM/sink view.
interface ref_rom_seq_if #(
    parameter int unsigned pDAT_W  = 24,
    parameter int unsigned pADDR_W = 10
);
    logic               istart;
    logic [2:0]         ibw;
    logic               ird;
    logic [pDAT_W-1:0]  irom_dat;
    logic [pADDR_W-1:0] oaddr;
    logic [2:0]         obw;
    logic [pDAT_W-1:0]  odat;
    logic               oval;
    logic               osop;
    logic               oeop;
    logic               obusy;
    logic               oerr;

    modport slave (
        input  istart, ibw, ird, irom_dat,
        output oaddr, obw, odat, oval, osop, oeop, obusy, oerr
    );

    modport master (
        output istart, ibw, ird, irom_dat,
        input  oaddr, obw, odat, oval, osop, oeop, obusy, oerr
    );
endinterface

// File: rtl/ref_rom_seq.sv
// Preamble reference ROM sequencer: walks the ROM once per start and frames the registered data.
// Define REF_SEQ_LOOP_EN to chain passes back-to-back while istart is held at the last address.
module ref_rom_seq #(
    parameter int unsigned pDAT_W   = 24,
    parameter int unsigned pDAT_Num = 1024,
    parameter logic [7:0]  pBW_MASK = 8'b0010_0001
) (
    input logic          iclk,
    input logic          irst_n,
    ref_rom_seq_if.slave bus
);
    localparam int unsigned AddrW = $clog2(pDAT_Num);
    localparam logic [AddrW-1:0] LastAddr = AddrW'(pDAT_Num - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e             state_q, state_d;
    logic [AddrW-1:0]   addr_q, addr_d;
    logic [2:0]         bw_q, bw_d;
    logic [pDAT_W-1:0]  dat_q, dat_d;
    logic               val_q, val_d;
    logic               sop_q, sop_d;
    logic               eop_q, eop_d;
    logic               err_q, err_d;

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            bw_q    <= '0;
            dat_q   <= '0;
            val_q   <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            bw_q    <= bw_d;
            dat_q   <= dat_d;
            val_q   <= val_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        bw_d    = bw_q;
        dat_d   = dat_q;
        val_d   = 1'b0;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.istart) begin
                    if (pBW_MASK[bus.ibw]) begin
                        bw_d    = bus.ibw;
                        addr_d  = '0;
                        state_d = StRun;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (bus.ird) begin
                    dat_d  = bus.irom_dat;
                    val_d  = 1'b1;
                    sop_d  = (addr_q == '0);
                    eop_d  = (addr_q == LastAddr);
                    // Natural overflow returns the address to 0 after the last sample.
                    addr_d = addr_q + AddrW'(1);
                    if (addr_q == LastAddr) begin
`ifdef REF_SEQ_LOOP_EN
                        state_d = bus.istart ? StRun : StIdle;
`else
                        state_d = StIdle;
`endif
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.oaddr = addr_q;
    assign bus.obw   = bw_q;
    assign bus.odat  = dat_q;
    assign bus.oval  = val_q;
    assign bus.osop  = sop_q;
    assign bus.oeop  = eop_q;
    assign bus.obusy = (state_q == StRun);
    assign bus.oerr  = err_q;
endmodule
